// File: rtl/cdb_scheduler_pkg.sv
// Shared types and constants for the common-data-bus scheduler.
package cdb_scheduler_pkg;

    localparam int unsigned NUM_CDB = 2;

    typedef logic [3:0]                 cdb_age_t;
    typedef logic [$clog2(NUM_CDB)-1:0] cdb_sel_t;

endpackage

// File: rtl/cdb_scheduler_if.sv
// Clock/reset bundle shared by the scheduler and the combos around it.
interface IntfCSB;

    logic clk;
    logic reset;

    modport master (output clk, output reset);
    modport slave  (input  clk, input  reset);

endinterface

// File: rtl/cdb_scheduler_rr_picker.sv
// Combinational round-robin picker: lowest-index priority request wins,
// otherwise the first request at or after ptr, wrapping.
module rr_picker #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         prio,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    logic [N-1:0] hi_mask;
    logic [N-1:0] starve;
    logic [N-1:0] upper;

    function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (v[i-1]) r = IW'(i - 1);
        end
        return r;
    endfunction

    // Wrap-around search done as two passes: requests at or above ptr first,
    // then the full vector, which only matters when nothing lies above ptr.
    always_comb begin
        hi_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            hi_mask[i] = (IW'(i) >= ptr);
        end
        starve = req & prio;
        upper  = req & hi_mask;
        valid  = |req;
        if (|starve)     idx = lowest(starve);
        else if (|upper) idx = lowest(upper);
        else             idx = lowest(req);
    end

endmodule

// File: rtl/cdb_scheduler.sv
// Grants up to one requester per CDB per cycle: round-robin with aging
// promotion, per-bus stall masking and flush; all outputs registered.
module cdb_scheduler
    import cdb_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 8,
    parameter int unsigned STARVE_LIMIT = 7
) (
    IntfCSB.slave                                        cs,
    input  logic [NUM_REQ-1:0]                           i_get_bus,
    input  logic [NUM_CDB-1:0]                           i_bus_stall,
    input  logic                                         i_flush,
    output logic [NUM_REQ-1:0]                           o_bus_granted,
    output cdb_sel_t [NUM_REQ-1:0]                       o_bus_selected,
    output logic [NUM_CDB-1:0]                           o_owner_valid,
    output logic [NUM_CDB-1:0][$clog2(NUM_REQ)-1:0]      o_owner
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]               grant_q, grant_d;
    cdb_sel_t [NUM_REQ-1:0]           sel_q, sel_d;
    logic [NUM_CDB-1:0]               vld_q, vld_d;
    logic [NUM_CDB-1:0][IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]                    rr_ptr_q, rr_ptr_d;
    cdb_age_t                         age_q [NUM_REQ];
    cdb_age_t                         age_d [NUM_REQ];

    logic [NUM_REQ-1:0] elig, elig2, starving;
    logic [NUM_CDB-1:0] free;
    logic               v1, v2;
    logic [IW-1:0]      idx1, idx2;
    cdb_sel_t           bus1;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        elig = i_get_bus & ~grant_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            starving[k] = (age_q[k] == cdb_age_t'(STARVE_LIMIT));
        end
        elig2 = elig & ~(NUM_REQ'(1) << idx1);
    end

    rr_picker #(.N(NUM_REQ)) u_pick1 (
        .req   (elig),
        .prio  (starving),
        .ptr   (rr_ptr_q),
        .valid (v1),
        .idx   (idx1)
    );

    rr_picker #(.N(NUM_REQ)) u_pick2 (
        .req   (elig2),
        .prio  (starving),
        .ptr   (rr_ptr_q),
        .valid (v2),
        .idx   (idx2)
    );

    // Pick 1 lands on the lowest free bus; pick 2 only when both are free.
    always_comb begin
        free     = ~i_bus_stall;
        bus1     = free[0] ? cdb_sel_t'(0) : cdb_sel_t'(1);
        grant_d  = '0;
        sel_d    = '0;
        vld_d    = '0;
        owner_d  = '0;
        rr_ptr_d = rr_ptr_q;
        if (!i_flush && v1 && (|free)) begin
            grant_d[idx1] = 1'b1;
            sel_d[idx1]   = bus1;
            vld_d[bus1]   = 1'b1;
            owner_d[bus1] = idx1;
            rr_ptr_d      = next_ptr(idx1);
            if ((&free) && v2) begin
                grant_d[idx2] = 1'b1;
                sel_d[idx2]   = cdb_sel_t'(1);
                vld_d[1]      = 1'b1;
                owner_d[1]    = idx2;
                rr_ptr_d      = next_ptr(idx2);
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (i_flush || !i_get_bus[k] || grant_d[k])
                age_d[k] = '0;
            else if (elig[k] && !starving[k])
                age_d[k] = age_q[k] + cdb_age_t'(1);
            else
                age_d[k] = age_q[k];
        end
    end

    always_ff @(posedge cs.clk) begin
        if (cs.reset) begin
            grant_q  <= '0;
            sel_q    <= '0;
            vld_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            age_q    <= '{default: '0};
        end else begin
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            vld_q    <= vld_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            age_q    <= age_d;
        end
    end

    assign o_bus_granted  = grant_q;
    assign o_bus_selected = sel_q;
    assign o_owner_valid  = vld_q;
    assign o_owner        = owner_q;

endmodule

// File: tb/tb_cdb_scheduler.sv
// Randomized scoreboard bench for cdb_scheduler against a behavioural model.
module tb_cdb_scheduler;

    localparam int N     = 8;
    localparam int LIMIT = 7;

    IntfCSB cs ();

    logic [N-1:0]      get_bus;
    logic [1:0]        bus_stall;
    logic              flush;
    logic [N-1:0]      granted;
    logic [N-1:0]      selected;
    logic [1:0]        owner_valid;
    logic [1:0][2:0]   owner;

    cdb_scheduler #(.NUM_REQ(N), .STARVE_LIMIT(LIMIT)) dut (
        .cs             (cs),
        .i_get_bus      (get_bus),
        .i_bus_stall    (bus_stall),
        .i_flush        (flush),
        .o_bus_granted  (granted),
        .o_bus_selected (selected),
        .o_owner_valid  (owner_valid),
        .o_owner        (owner)
    );

    initial cs.clk = 1'b0;
    always #5 cs.clk = ~cs.clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic [N-1:0] sel;
        logic [1:0]   vld;
        int           own0;
        int           own1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: what the scheduler remembers between cycles.
    int           m_age [N];
    int           m_ptr;
    logic [N-1:0] m_prev;

    function automatic int pick(input logic [N-1:0] e);
        for (int k = 0; k < N; k++)
            if (e[k] && m_age[k] == LIMIT) return k;
        for (int off = 0; off < N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (e[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] g, input logic [1:0] st,
                              input bit fl, input bit rst);
        exp_t         e;
        logic [N-1:0] elig;
        logic [N-1:0] rest;
        int           p1, p2, last, b;
        e.gnt = '0; e.sel = '0; e.vld = '0; e.own0 = 0; e.own1 = 0;
        if (rst) begin
            for (int k = 0; k < N; k++) m_age[k] = 0;
            m_ptr  = 0;
            m_prev = '0;
        end else begin
            elig = g & ~m_prev;
            last = -1;
            if (!fl && st != 2'b11) begin
                p1 = pick(elig);
                if (p1 >= 0) begin
                    b = st[0] ? 1 : 0;
                    e.gnt[p1] = 1'b1;
                    e.sel[p1] = (b == 1);
                    e.vld[b]  = 1'b1;
                    if (b == 0) e.own0 = p1; else e.own1 = p1;
                    last = p1;
                    if (st == 2'b00) begin
                        rest = elig;
                        rest[p1] = 1'b0;
                        p2 = pick(rest);
                        if (p2 >= 0) begin
                            e.gnt[p2] = 1'b1;
                            e.sel[p2] = 1'b1;
                            e.vld[1]  = 1'b1;
                            e.own1    = p2;
                            last      = p2;
                        end
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (fl || !g[k] || e.gnt[k]) m_age[k] = 0;
                else if (elig[k] && m_age[k] < LIMIT) m_age[k]++;
            end
            if (last >= 0) m_ptr = (last + 1) % N;
            m_prev = e.gnt;
        end
        q.push_back(e);
    endtask

    // Drive one cycle of stimulus; takes effect on the next rising edge.
    task automatic step(input logic [N-1:0] g, input logic [1:0] st,
                        input bit fl, input bit rst);
        get_bus   = g;
        bus_stall = st;
        flush     = fl;
        cs.reset  = rst;
        model_step(g, st, fl, rst);
        @(negedge cs.clk);
    endtask

    // Monitor: one registered output set per cycle, compared against the queue.
    initial begin
        exp_t         e;
        logic [N-1:0] prev_g;
        logic [1:0]   vchk;
        prev_g = '0;
        forever begin
            @(posedge cs.clk);
            #1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: output present at %0t with no expected entry", $time);
            end else begin
                e = q.pop_front();
                if (granted !== e.gnt || selected !== (e.sel & e.gnt) ||
                    owner_valid !== e.vld ||
                    (e.vld[0] && owner[0] !== 3'(e.own0)) ||
                    (e.vld[1] && owner[1] !== 3'(e.own1)) ||
                    (!e.vld[0] && owner[0] !== 3'd0) ||
                    (!e.vld[1] && owner[1] !== 3'd0)) begin
                    errors++;
                    $display("FAIL grant @%0t: got gnt=%b sel=%b vld=%b own=%0d/%0d, want gnt=%b sel=%b vld=%b own=%0d/%0d",
                             $time, granted, selected & granted, owner_valid, owner[1], owner[0],
                             e.gnt, e.sel & e.gnt, e.vld, e.own1, e.own0);
                end
            end
            checks++;
            vchk[0] = |(granted & ~selected);
            vchk[1] = |(granted & selected);
            if ($countones(granted) > 2 || (granted & prev_g) != '0 || vchk !== owner_valid) begin
                errors++;
                $display("FAIL invariant @%0t: gnt=%b prev=%b sel=%b vld=%b",
                         $time, granted, prev_g, selected, owner_valid);
            end
            prev_g = granted;
        end
    end

    initial begin
        step(8'h00, 2'b00, 1'b0, 1'b1);
        step(8'h00, 2'b00, 1'b0, 1'b1);
        repeat (5) step(8'h00, 2'b00, 1'b0, 1'b0);
        // Two requesters, both buses free.
        step(8'b0000_0101, 2'b00, 1'b0, 1'b0);
        step(8'h00, 2'b00, 1'b0, 1'b0);
        step(8'h00, 2'b00, 1'b0, 1'b0);
        // Everyone requesting continuously.
        repeat (12) step(8'hFF, 2'b00, 1'b0, 1'b0);
        // Bus 0 stalled, requests 1 and 3 from rr_ptr = 0.
        step(8'h00, 2'b00, 1'b0, 1'b1);
        repeat (4) step(8'b0000_1010, 2'b01, 1'b0, 1'b0);
        // Bus 1 stalled, requesters 0..4 contending for one bus.
        repeat (12) step(8'h1F, 2'b10, 1'b0, 1'b0);
        // Flush while 6 and 7 are pending.
        step(8'hC0, 2'b11, 1'b0, 1'b0);
        step(8'hC0, 2'b00, 1'b1, 1'b0);
        repeat (3) step(8'hC0, 2'b00, 1'b0, 1'b0);
        // Reset with requests present.
        step(8'hFF, 2'b00, 1'b0, 1'b1);
        step(8'hFF, 2'b00, 1'b0, 1'b0);
        step(8'h00, 2'b00, 1'b0, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] g;
            logic [1:0]   st;
            bit           fl, rs;
            g  = N'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 59) == 0);
            step(g, st, fl, rs);
        end
        step(8'h00, 2'b00, 1'b0, 1'b0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_scheduler.md
# cdb_scheduler

Central scheduler for the two common data buses (CDB). It collects bus requests from every functional combo (ALU, load/store, branch, mul/div, …) and grants at most one requester per bus per cycle. Allocation is round-robin, with anti-starvation aging and per-bus stall masking. It replaces per-combo address decoding: each combo's `o_bus_granted`/`o_bus_selected` pair is driven from here.

## Interface
Parameters:
- `NUM_REQ`, 8, number of requesting combos (2..16).
- `STARVE_LIMIT`, 7, wait cycles after which a request is promoted to starving priority (1..15).

Ports:
- `cs`  input  IntfCSB  `cs.clk` is the single clock; `cs.reset` is a synchronous, active-high reset.
- `i_get_bus`  input  NUM_REQ  request vector; bit k high means combo k holds a result.
- `i_bus_stall`  input  2  bus b cannot accept a result this cycle.
- `i_flush`  input  1  pipeline flush: no grants are issued this cycle and ages are cleared.
- `o_bus_granted`  output  NUM_REQ  one-cycle grant pulse per requester.
- `o_bus_selected`  output  NUM_REQ  bus index for a granted requester: 0 = CDB0, 1 = CDB1. Valid only with the matching grant bit.
- `o_owner_valid`  output  2  bus b carries a grant this cycle.
- `o_owner`  output  2×$clog2(NUM_REQ)  requester index driving bus b.

## Operation
- Eligible requesters are computed combinationally:
  - eligible = `i_get_bus` & ~`o_bus_granted`.
  - A requester is never granted in two consecutive cycles. This lets a combo drop its request in the cycle it sees the grant.
- Each requester k has an age counter `age[k]` (4 bit):
  - Increments each cycle the requester is eligible but not granted.
  - Saturates at STARVE_LIMIT.
  - Clears on grant, on request deassertion, and on `i_flush`.
- Pick order:
  - Pick 1 goes to the lowest-index starving requester (age == STARVE_LIMIT). If none is starving, it goes to the first eligible requester at or after `rr_ptr`, wrapping around.
  - Pick 2 uses the same rule with pick 1 excluded.
- Bus assignment: pick 1 takes the lowest-index non-stalled bus and pick 2 takes the other one. If one bus is stalled, only pick 1 is issued, on the free bus. If both buses are stalled, there are no grants.
- `rr_ptr` update: when any grant is issued, it moves to (index of the last issued pick + 1) mod NUM_REQ. Otherwise it is held.
- `i_flush` blocks all grants in that cycle and clears all ages. `rr_ptr` is held.
- No requests: all outputs go to 0 on the next edge.

## Timing
- All outputs are registered. A request sampled at edge t produces a grant that is visible during cycle t+1, for exactly one cycle.
- A combo holding its request continuously is re-eligible at t+2.
- Worst-case wait for any continuous requester is bounded by STARVE_LIMIT + ceil(NUM_REQ/2) cycles.
- Reset (synchronous):
  - All outputs are 0.
  - `rr_ptr` = 0 and all ages = 0.
  - Reset asserted mid-operation cancels the grant that would have been issued on the next edge.
- Simultaneous events:
  - `i_flush` overrides requests and the starving rule.
  - `cs.reset` overrides everything.
- Invariants:
  - No two grants on the same bus.
  - A requester is never granted both buses.
  - `o_owner_valid[b]` equals the OR of the `o_bus_granted` bits assigned to b.
  - `popcount(o_bus_granted)` ≤ 2.

## Structure
- `pkg_defines` gains:
  - `NUM_CDB` = 2.
  - `typedef logic [3:0] cdb_age_t`.
  - `typedef logic [$clog2(NUM_CDB)-1:0] cdb_sel_t`.
- One sub-module, `rr_picker`:
  - Parameter N; inputs `req[N]`, `prio[N]`, `ptr`; outputs `valid`, `idx`.
  - Purely combinational; instantiated twice in cascade.
- The top level holds `rr_ptr`, the age array, bus assignment and the output registers.
- This block is instantiated once, next to the combos. Each combo's `CDBArbiter` consumes this block's per-requester `o_bus_granted` and `o_bus_selected` bits.

## Test plan
- Reset, then `i_get_bus`=8'h00 for 5 cycles → all outputs 0 and `rr_ptr`=0.
- `i_get_bus`=8'b0000_0101 held for 1 cycle:
  - Next cycle: grant=8'b0000_0101, req0→bus0, req2→bus1, `o_owner`={2,0}, `rr_ptr`=3.
- All 8 requesting continuously with no stalls → each requester is granted at least once every 5 cycles and no requester is granted in consecutive cycles.
- `i_bus_stall`=2'b01 with requests 1 and 3 (`rr_ptr`=0):
  - Only req1 is granted, on bus1.
  - req3 is granted on a later cycle.
- Starvation: `i_bus_stall`=2'b10, req4 requesting continuously from the first request cycle, reqs 0–3 re-requesting each cycle, STARVE_LIMIT=7 → req4 is granted within 8 cycles of its first request.
- `i_flush` pulsed while requests 6 and 7 are pending:
  - No grant in the following cycle and ages are cleared.
  - Grants resume one cycle after the flush drops.
- Reset asserted in the same cycle as requests → no grant in the following cycle.
